mext_issue_lock: RTL and testbench
==================================

MEXT_ISSUE_LOCK -- requirements
Module: mext_issue_lock

Interface
REQ-001 Parameter XLEN, default 32, operand width.
REQ-002 Parameter NUM_UNITS, default 2, number of multi-cycle units (bit 0 = mul, bit 1 = div), range 1..8.
REQ-003 Parameter STALL_W, default 6, width of pipeline stall vector.
REQ-004 Parameter STALL_BIT, default 2, stall bit index of the EX stage.
REQ-005 Parameter TIMEOUT, default 64, maximum cycles in BUSY before forced release; 0 disables the timeout.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 stall  in  STALL_W  pipeline stall vector.
REQ-009 flush  in  1  pipeline flush; kills any locked operation.
REQ-010 req  in  NUM_UNITS  per-unit issue enables from EX.
REQ-011 src_a, src_b  in  XLEN each  live EX operands.
REQ-012 unit_busy  in  NUM_UNITS  per-unit stall requests; high while the unit computes.
REQ-013 op_a, op_b  out  XLEN each  operands presented to the units.
REQ-014 start  out  NUM_UNITS  one-cycle start pulse, one-hot or zero.
REQ-015 abort  out  NUM_UNITS  one-cycle kill pulse to the granted unit.
REQ-016 lock_busy  out  1  high when state is not IDLE.
REQ-017 grant_idx  out  clog2(NUM_UNITS), minimum 1 bit  index of the locked unit.
REQ-018 err_multi, err_timeout  out  1 each  sticky error flags.

Function
REQ-019 States SHALL be IDLE, BUSY and HOLD, with a registered XLEN operand buffer pair and a registered grant index.
REQ-020 In IDLE, op_a/op_b SHALL equal src_a/src_b combinationally; in BUSY/HOLD, they SHALL equal the buffers.
REQ-021 In IDLE with req != 0 and flush = 0, the lowest set bit of req SHALL be granted and start[g] SHALL assert the same cycle; at the clock edge src_a/src_b SHALL be captured, grant_idx = g, and state SHALL go to BUSY.
REQ-022 More than one req bit set on a grant SHALL set err_multi; only the lowest unit starts.
REQ-023 start SHALL be zero in BUSY and HOLD, so each issue produces exactly one start pulse.
REQ-024 In BUSY, when unit_busy[g] = 0 and req[g] = 1: go to IDLE if stall[STALL_BIT] = 0, else go to HOLD.
REQ-025 In HOLD, stay until stall[STALL_BIT] = 0, then go to IDLE; buffers stay held until then.
REQ-026 In BUSY, req[g] = 0 without flush SHALL pulse abort[g] and go to IDLE.
REQ-027 flush = 1 in BUSY or HOLD SHALL pulse abort[g] that cycle and force IDLE; flush in IDLE SHALL suppress start.
REQ-028 A BUSY-cycle counter SHALL clear on entry to BUSY; when it reaches TIMEOUT (TIMEOUT > 0), set err_timeout, pulse abort[g] and go to IDLE.
REQ-029 Priority per cycle: flush > timeout > req drop > completion.
REQ-030 On every return to IDLE, buffers SHALL clear to 0.
REQ-031 A new req in the cycle the FSM returns to IDLE SHALL be granted on the following cycle, never the same edge.
REQ-032 err_multi and err_timeout SHALL clear only on reset.

Reset
REQ-033 While rst = 1: state IDLE, buffers 0, grant_idx 0, counter 0, err flags 0, start 0, abort 0, lock_busy 0; op_a/op_b follow src_a/src_b.
REQ-034 Reset asserted mid-BUSY SHALL return to IDLE immediately and asynchronously with no abort pulse.

Verification
REQ-035 The bench SHALL cover: req = 01, src_a = 5, src_b = 7, unit_busy[0] high 3 cycles, stall = 0 -> one start[0] pulse, op_a = 5 / op_b = 7 held through BUSY, IDLE the cycle after unit_busy falls.
REQ-036 The bench SHALL cover: src_a changed to 9 during BUSY -> op_a stays 5.
REQ-037 The bench SHALL cover: completion with stall[2] = 1 for 2 cycles -> HOLD for 2 cycles, no second start, then IDLE.
REQ-038 The bench SHALL cover: req = 11 -> start = 01, grant_idx = 0, err_multi = 1.
REQ-039 The bench SHALL cover: flush in BUSY with grant 1 -> abort = 10 for one cycle, next-cycle state IDLE, buffers 0.
REQ-040 The bench SHALL cover: TIMEOUT = 4 with unit_busy stuck high -> abort after 4 BUSY cycles, err_timeout = 1 until reset.

Source files
------------

// File: rtl/mext_issue_lock_if.sv
`default_nettype none
// ============================================================================
// Module      : mext_issue_lock_if
// Description : EX-stage / multi-cycle unit issue-lock bus. The master side
//               is the pipeline plus the mul/div units, the slave side is
//               the issue lock itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface mext_issue_lock_if #(
    parameter int XLEN      = 32,
    parameter int NUM_UNITS = 2,
    parameter int STALL_W   = 6
);
    localparam int c_gidx_w = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [STALL_W-1:0]   stall;
    logic                 flush;
    logic [NUM_UNITS-1:0] req;
    logic [XLEN-1:0]      src_a;
    logic [XLEN-1:0]      src_b;
    logic [NUM_UNITS-1:0] unit_busy;
    logic [XLEN-1:0]      op_a;
    logic [XLEN-1:0]      op_b;
    logic [NUM_UNITS-1:0] start;
    logic [NUM_UNITS-1:0] abort;
    logic                 lock_busy;
    logic [c_gidx_w-1:0]  grant_idx;
    logic                 err_multi;
    logic                 err_timeout;

    modport master (
        output stall, flush, req, src_a, src_b, unit_busy,
        input  op_a, op_b, start, abort, lock_busy, grant_idx, err_multi, err_timeout
    );

    modport slave (
        input  stall, flush, req, src_a, src_b, unit_busy,
        output op_a, op_b, start, abort, lock_busy, grant_idx, err_multi, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/mext_issue_lock.sv
`default_nettype none
// ============================================================================
// Module      : mext_issue_lock
// Description : Locks the EX operands of a multi-cycle M-extension operation
//               for its whole lifetime, issues a single start pulse to the
//               lowest requesting unit and kills it on flush, req drop or a
//               BUSY timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mext_issue_lock #(
    parameter int XLEN      = 32,
    parameter int NUM_UNITS = 2,
    parameter int STALL_W   = 6,
    parameter int STALL_BIT = 2,
    parameter int TIMEOUT   = 64
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mext_issue_lock_if.slave   bus
);
    localparam int c_gidx_w = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int c_cnt_w  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value seen in the last permitted BUSY cycle: the lock is
    // released in the TIMEOUT-th BUSY cycle.
    localparam logic [c_cnt_w-1:0] c_cnt_last = (TIMEOUT > 0) ? c_cnt_w'(TIMEOUT - 1) : '0;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_hold = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [XLEN-1:0]     r_op_a;
    logic [XLEN-1:0]     r_op_b;
    logic [c_gidx_w-1:0] r_grant;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_err_multi;
    logic                r_err_timeout;

    logic [c_gidx_w-1:0] w_gidx;
    logic                w_issue;
    logic                w_multi;
    logic                w_req_g;
    logic                w_busy_g;
    logic                w_stall_ex;
    logic                w_timeout;
    logic                w_kill;
    logic                w_release;

    // Lowest set request bit wins the grant.
    always_comb begin
        w_gidx = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (bus.req[i]) w_gidx = c_gidx_w'(i);
        end
    end

    assign w_issue    = (r_state == c_idle) && (|bus.req) && !bus.flush;
    assign w_multi    = (bus.req & (bus.req - NUM_UNITS'(1))) != '0;
    assign w_req_g    = bus.req[r_grant];
    assign w_busy_g   = bus.unit_busy[r_grant];
    assign w_stall_ex = bus.stall[STALL_BIT];
    assign w_timeout  = (TIMEOUT > 0) && (r_state == c_busy) && (r_cnt == c_cnt_last);
    // Any forced release of a locked operation; completion is not a kill.
    assign w_kill     = ((r_state == c_busy) && (bus.flush || w_timeout || !w_req_g))
                     || ((r_state == c_hold) && bus.flush);
    assign w_release  = (r_state != c_idle) && (w_next_state == c_idle);

    // State register; reset drops straight to IDLE with no abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_idle;
        else     r_state <= w_next_state;
    end

    // Next state: flush > timeout > req drop > completion.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: if (w_issue) w_next_state = c_busy;
            c_busy: begin
                if (w_kill)         w_next_state = c_idle;
                else if (!w_busy_g) w_next_state = w_stall_ex ? c_hold : c_idle;
            end
            c_hold: if (bus.flush || !w_stall_ex) w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // Operand buffers, grant index, BUSY counter and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_grant       <= '0;
            r_cnt         <= '0;
            r_err_multi   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_issue) begin
                r_op_a  <= bus.src_a;
                r_op_b  <= bus.src_b;
                r_grant <= w_gidx;
                r_cnt   <= '0;
                if (w_multi) r_err_multi <= 1'b1;
            end else if (w_release) begin
                r_op_a <= '0;
                r_op_b <= '0;
            end
            if (r_state == c_busy) r_cnt <= r_cnt + c_cnt_w'(1);
            if (w_timeout) r_err_timeout <= 1'b1;
        end
    end

    // Outputs: operand mux, single start pulse from IDLE, abort on kill.
    always_comb begin
        bus.start = '0;
        if (w_issue && !rst) bus.start = NUM_UNITS'(1) << w_gidx;
        bus.abort = '0;
        if (w_kill) bus.abort = NUM_UNITS'(1) << r_grant;
        bus.op_a        = (r_state == c_idle) ? bus.src_a : r_op_a;
        bus.op_b        = (r_state == c_idle) ? bus.src_b : r_op_b;
        bus.lock_busy   = (r_state != c_idle);
        bus.grant_idx   = r_grant;
        bus.err_multi   = r_err_multi;
        bus.err_timeout = r_err_timeout;
    end
endmodule
`default_nettype wire

// File: tb/tb_mext_issue_lock.sv
`default_nettype none
// ============================================================================
// Module      : tb_mext_issue_lock
// Description : Directed self-checking bench for mext_issue_lock. dut_a uses
//               the default timeout, dut_b a timeout of 4 BUSY cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mext_issue_lock;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mext_issue_lock_if #(.XLEN(32), .NUM_UNITS(2), .STALL_W(6)) ifa ();
    mext_issue_lock_if #(.XLEN(32), .NUM_UNITS(2), .STALL_W(6)) ifb ();

    mext_issue_lock #(.XLEN(32), .NUM_UNITS(2), .STALL_W(6), .STALL_BIT(2), .TIMEOUT(64))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mext_issue_lock #(.XLEN(32), .NUM_UNITS(2), .STALL_W(6), .STALL_BIT(2), .TIMEOUT(4))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        ifa.stall = '0; ifa.flush = 1'b0; ifa.req = 2'b01;
        ifa.src_a = 32'd3; ifa.src_b = 32'd4; ifa.unit_busy = '0;
        ifb.stall = '0; ifb.flush = 1'b0; ifb.req = 2'b00;
        ifb.src_a = '0; ifb.src_b = '0; ifb.unit_busy = '0;
        #1;
        // Reset state, with a request pending that must not start.
        chk("rst_start", 32'(ifa.start), 32'h0);
        chk("rst_abort", 32'(ifa.abort), 32'h0);
        chk("rst_lock_busy", 32'(ifa.lock_busy), 32'h0);
        chk("rst_op_a", ifa.op_a, 32'd3);
        chk("rst_grant", 32'(ifa.grant_idx), 32'h0);
        chk("rst_err_multi", 32'(ifa.err_multi), 32'h0);
        chk("rst_err_timeout", 32'(ifb.err_timeout), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        ifa.req = 2'b00;
        tick();

        // Basic lock: mul issue, unit busy 3 cycles, no stall.
        ifa.req = 2'b01; ifa.src_a = 32'd5; ifa.src_b = 32'd7;
        #1;
        chk("t1_start", 32'(ifa.start), 32'h1);
        chk("t1_idle_op_a", ifa.op_a, 32'd5);
        tick();
        chk("t1_busy", 32'(ifa.lock_busy), 32'h1);
        chk("t1_no_restart", 32'(ifa.start), 32'h0);
        chk("t1_op_b", ifa.op_b, 32'd7);
        chk("t1_grant", 32'(ifa.grant_idx), 32'h0);
        ifa.unit_busy = 2'b01; ifa.src_a = 32'd9; ifa.src_b = 32'd8;
        #1;
        chk("t1_op_a_held", ifa.op_a, 32'd5);
        tick();
        chk("t1_busy2_op_a", ifa.op_a, 32'd5);
        tick();
        chk("t1_busy3_op_b", ifa.op_b, 32'd7);
        tick();
        ifa.unit_busy = 2'b00;
        #1;
        chk("t1_done_abort", 32'(ifa.abort), 32'h0);
        chk("t1_done_busy", 32'(ifa.lock_busy), 32'h1);
        tick();
        ifa.req = 2'b00;
        #1;
        chk("t1_idle", 32'(ifa.lock_busy), 32'h0);
        chk("t1_idle_op_a", ifa.op_a, 32'd9);
        chk("t1_buf_clear", dut_a.r_op_a, 32'h0);

        // Completion under EX stall: two HOLD cycles, no second start.
        ifa.req = 2'b01; ifa.src_a = 32'd1; ifa.src_b = 32'd2;
        #1;
        chk("t2_start", 32'(ifa.start), 32'h1);
        tick();
        ifa.unit_busy = 2'b01; ifa.src_a = 32'd6; ifa.src_b = 32'd6;
        tick();
        ifa.unit_busy = 2'b00; ifa.stall = 6'b000100;
        #1;
        chk("t2_done_busy", 32'(ifa.lock_busy), 32'h1);
        tick();
        chk("t2_hold1_state", 32'(dut_a.r_state), 32'd2);
        chk("t2_hold1_start", 32'(ifa.start), 32'h0);
        chk("t2_hold1_op_a", ifa.op_a, 32'd1);
        tick();
        ifa.stall = 6'b000000;
        #1;
        chk("t2_hold2_state", 32'(dut_a.r_state), 32'd2);
        chk("t2_hold2_op_b", ifa.op_b, 32'd2);
        chk("t2_hold2_start", 32'(ifa.start), 32'h0);
        tick();
        ifa.req = 2'b00;
        #1;
        chk("t2_idle", 32'(ifa.lock_busy), 32'h0);

        // Multiple requests: lowest wins, err_multi set; then req drop aborts.
        ifa.req = 2'b11; ifa.src_a = 32'd4; ifa.src_b = 32'd4;
        #1;
        chk("t3_start", 32'(ifa.start), 32'h1);
        chk("t3_err_pre", 32'(ifa.err_multi), 32'h0);
        tick();
        chk("t3_grant", 32'(ifa.grant_idx), 32'h0);
        chk("t3_err_multi", 32'(ifa.err_multi), 32'h1);
        ifa.req = 2'b00;
        #1;
        chk("t3_drop_abort", 32'(ifa.abort), 32'h1);
        tick();
        chk("t3_idle", 32'(ifa.lock_busy), 32'h0);
        chk("t3_abort_clr", 32'(ifa.abort), 32'h0);
        chk("t3_err_sticky", 32'(ifa.err_multi), 32'h1);

        // Flush while div is locked.
        ifa.req = 2'b10; ifa.src_a = 32'hA; ifa.src_b = 32'hB;
        #1;
        chk("t4_start", 32'(ifa.start), 32'h2);
        tick();
        chk("t4_grant", 32'(ifa.grant_idx), 32'h1);
        ifa.unit_busy = 2'b10; ifa.flush = 1'b1;
        #1;
        chk("t4_flush_abort", 32'(ifa.abort), 32'h2);
        tick();
        ifa.flush = 1'b0; ifa.req = 2'b00; ifa.unit_busy = 2'b00;
        #1;
        chk("t4_idle", 32'(ifa.lock_busy), 32'h0);
        chk("t4_abort_clr", 32'(ifa.abort), 32'h0);
        chk("t4_buf_a", dut_a.r_op_a, 32'h0);
        chk("t4_buf_b", dut_a.r_op_b, 32'h0);
        ifa.flush = 1'b1; ifa.req = 2'b01;
        #1;
        chk("t4_idle_flush_start", 32'(ifa.start), 32'h0);
        tick();
        chk("t4_idle_flush_state", 32'(ifa.lock_busy), 32'h0);
        ifa.flush = 1'b0; ifa.req = 2'b00;
        tick();

        // Asynchronous reset in the middle of BUSY.
        ifa.req = 2'b01;
        tick();
        chk("t5_busy", 32'(ifa.lock_busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("t5_rst_idle", 32'(ifa.lock_busy), 32'h0);
        chk("t5_rst_abort", 32'(ifa.abort), 32'h0);
        chk("t5_rst_start", 32'(ifa.start), 32'h0);
        chk("t5_rst_err", 32'(ifa.err_multi), 32'h0);
        tick();
        rst = 1'b0; ifa.req = 2'b00;
        tick();

        // Timeout of 4 BUSY cycles with the unit stuck busy.
        ifb.req = 2'b01; ifb.src_a = 32'd5; ifb.src_b = 32'd7;
        #1;
        chk("t6_start", 32'(ifb.start), 32'h1);
        tick();
        ifb.unit_busy = 2'b01;
        #1;
        chk("t6_b1_abort", 32'(ifb.abort), 32'h0);
        tick();
        chk("t6_b2_abort", 32'(ifb.abort), 32'h0);
        tick();
        chk("t6_b3_abort", 32'(ifb.abort), 32'h0);
        tick();
        chk("t6_b4_abort", 32'(ifb.abort), 32'h1);
        chk("t6_b4_busy", 32'(ifb.lock_busy), 32'h1);
        chk("t6_b4_err", 32'(ifb.err_timeout), 32'h0);
        tick();
        ifb.req = 2'b00; ifb.unit_busy = 2'b00;
        #1;
        chk("t6_idle", 32'(ifb.lock_busy), 32'h0);
        chk("t6_err_set", 32'(ifb.err_timeout), 32'h1);
        tick();
        tick();
        chk("t6_err_sticky", 32'(ifb.err_timeout), 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_err_rst", 32'(ifb.err_timeout), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
